ma_mem_access_unit: RTL and testbench
=====================================

// Module: ma_mem_access_unit
// PURPOSE
//  MEM stage: consumes EX/MEM register outputs and runs LW/SW on the data memory via req/ready handshake.
//  Stalls upstream while an access is outstanding; selects the writeback value.
//  Contains the MEM/WB pipeline register feeding the WB stage.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max WAIT cycles before an access is aborted (>=1)
//  CNT_W           5   width of wait counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  ma_pc_plus_4_in     in  32  PC+4 of instruction in MEM
//  ma_alu_result_in    in  32  ALU result / memory address
//  ma_write_data_in    in  32  store data (rs2)
//  ma_rd_addr_in       in  5   destination register
//  ma_mem_read_in      in  1   load
//  ma_mem_write_in     in  1   store
//  ma_reg_write_in     in  1   writes rd
//  ma_mem_to_reg_in    in  1   rd <- load data
//  ma_write_from_pc_in in  1   rd <- PC+4 (JAL/JALR)
//  dmem_req        out  1   access request
//  dmem_we         out  1   1=write, 0=read
//  dmem_addr       out  32  byte address
//  dmem_wdata      out  32  store data
//  dmem_ready      in   1   access complete this cycle
//  dmem_rdata      in   32  load data, valid when dmem_ready
//  ma_stall        out  1   freeze PC, IF/ID, ID/EX, EX/MEM
//  ma_timeout      out  1   one-cycle pulse: access aborted
//  ma_misalign     out  1   one-cycle pulse: misaligned access (macro only)
//  wb_rd_addr_out      out 5   MEM/WB rd
//  wb_reg_write_out    out 1   MEM/WB write enable
//  wb_result_out       out 32  MEM/WB writeback value
// BEHAVIOUR
//  - acc = ma_mem_read_in | ma_mem_write_in; both set -> store wins, treated as store.
//  - dmem_req = acc in IDLE or WAIT (combinational); dmem_we = ma_mem_write_in; addr/wdata pass-through.
//  - FSM IDLE: acc & dmem_ready -> stay IDLE (zero-wait, no stall); acc & ~ready -> WAIT.
//  - FSM WAIT: ready -> IDLE; cnt==TIMEOUT_CYCLES-1 & ~ready -> IDLE, ma_timeout=1 next cycle.
//  - cnt: cleared in IDLE, +1 per WAIT cycle without ready; never wraps.
//  - ma_stall = acc & ~dmem_ready & ~timeout_abort (combinational); upstream inputs held stable while stalled.
//  - Result: write_from_pc ? pc_plus_4 : mem_to_reg ? load_data : alu_result.
//  - load_data = dmem_rdata on ready; 32'h0 on timeout abort.
//  - MEM/WB reg updates every clk: stalled -> bubble (reg_write=0, rd=0, result=0); else captures rd, reg_write, result.
//  - Store or timeout: reg_write forwarded as decoded (store has 0); timed-out load writes 0.
//  - Latency: result in WB one clk after dmem_ready (or after acc for non-memory ops).
//  - Reset (any time, incl. mid-WAIT): FSM=IDLE, cnt=0, all registered outputs 0, ma_timeout=0,
//    ma_misalign=0; dmem_req then follows acc combinationally.
//  - ready in IDLE without acc: ignored.
// CONFIGURATION
//  MA_MISALIGN_TRAP_EN defined:
//    acc & alu[1:0]!=0 -> dmem_req=0, no stall, ma_misalign pulses next cycle,
//    MEM/WB gets a bubble.
//  Not defined:
//    no check; dmem_addr = {alu[31:2],2'b00}; ma_misalign tied 0.
// TESTING
//  1. ALU op alu=32'h55, rd=5, reg_write=1 -> next clk wb_result=32'h55, wb_rd=5, no stall.
//  2. LW addr 32'h100, ready after 3 clks, rdata=32'hDEADBEEF -> stall 3 clks, WB bubbles,
//     then wb_result=32'hDEADBEEF.
//  3. SW addr 32'h200, wdata=32'h1234, ready same clk -> dmem_req=1, we=1, no stall, wb_reg_write=0.
//  4. LW, ready never -> stall exactly 16 clks, ma_timeout pulse, wb_result=0.
//  5. JAL write_from_pc, pc+4=32'h40 -> wb_result=32'h40.
//     rst mid-WAIT -> req only from acc, FSM IDLE, outputs 0.
//  6. Macro on: LW addr 32'h102 -> no req, ma_misalign pulse, WB bubble.
//     Macro off: dmem_addr=32'h100.

Source files
------------

// File: rtl/ma_dmem_if.sv
// Data-memory request/response bus between the MEM stage (master) and the data memory (slave).
interface ma_dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ready, input rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ready, output rdata);
endinterface

// File: rtl/ma_mem_access_unit.sv
// MEM stage: runs LW/SW over the dmem handshake, stalls upstream while waiting, holds MEM/WB register.
// Optional misaligned-access trap enabled by defining MA_MISALIGN_TRAP_EN.
module ma_mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ma_pc_plus_4_in,
    input  logic [31:0] ma_alu_result_in,
    input  logic [31:0] ma_write_data_in,
    input  logic [4:0]  ma_rd_addr_in,
    input  logic        ma_mem_read_in,
    input  logic        ma_mem_write_in,
    input  logic        ma_reg_write_in,
    input  logic        ma_mem_to_reg_in,
    input  logic        ma_write_from_pc_in,
    ma_dmem_if.master   dmem,
    output logic        ma_stall,
    output logic        ma_timeout,
    output logic        ma_misalign,
    output logic [4:0]  wb_rd_addr_out,
    output logic        wb_reg_write_out,
    output logic [31:0] wb_result_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          timeout_q, misalign_q;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_we_q, wb_we_d;
    logic [31:0]   wb_result_q, wb_result_d;

    logic          acc_s, misalign_s, req_s, abort_s, stall_s;
    logic [31:0]   load_data_s, result_s;

    assign acc_s = ma_mem_read_in | ma_mem_write_in;

`ifdef MA_MISALIGN_TRAP_EN
    assign misalign_s = acc_s & (ma_alu_result_in[1:0] != 2'b00);
    assign dmem.addr  = ma_alu_result_in;
`else
    logic unused_addr_lsb_s;
    assign unused_addr_lsb_s = ^ma_alu_result_in[1:0];
    assign misalign_s = 1'b0;
    assign dmem.addr  = {ma_alu_result_in[31:2], 2'b00};
`endif

    // A trapped misaligned access never reaches memory; store wins when both read and write are set.
    assign req_s      = acc_s & ~misalign_s;
    assign dmem.req   = req_s;
    assign dmem.we    = ma_mem_write_in;
    assign dmem.wdata = ma_write_data_in;

    // Handshake FSM: wait counter and timeout abort decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (req_s && !dmem.ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_s || dmem.ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    abort_s = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign stall_s  = req_s & ~dmem.ready & ~abort_s;
    assign ma_stall = stall_s;

    // Writeback selection and MEM/WB next state; stalled or trapped cycles insert a bubble.
    always_comb begin
        load_data_s = abort_s ? 32'h0000_0000 : dmem.rdata;
        if (ma_write_from_pc_in) begin
            result_s = ma_pc_plus_4_in;
        end else if (ma_mem_to_reg_in) begin
            result_s = load_data_s;
        end else begin
            result_s = ma_alu_result_in;
        end
        if (stall_s || misalign_s) begin
            wb_rd_d     = 5'd0;
            wb_we_d     = 1'b0;
            wb_result_d = 32'h0000_0000;
        end else begin
            wb_rd_d     = ma_rd_addr_in;
            wb_we_d     = ma_reg_write_in;
            wb_result_d = result_s;
        end
    end

    // State, counter, status pulses and MEM/WB pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            timeout_q   <= 1'b0;
            misalign_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_we_q     <= 1'b0;
            wb_result_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_q   <= abort_s;
            misalign_q  <= misalign_s;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
            wb_result_q <= wb_result_d;
        end
    end

    assign ma_timeout       = timeout_q;
    assign ma_misalign      = misalign_q;
    assign wb_rd_addr_out   = wb_rd_q;
    assign wb_reg_write_out = wb_we_q;
    assign wb_result_out    = wb_result_q;

endmodule

// File: tb/tb_ma_mem_access_unit.sv
// Directed self-checking bench for ma_mem_access_unit (ALU, LW wait/timeout, SW, JAL, reset, alignment).
module tb_ma_mem_access_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc4, alu, wdata;
    logic [4:0]  rd;
    logic        mrd, mwr, rwe, m2r, wfpc;
    logic        stall, tmo, mis;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_res;
    int          total;
    int          bad;
    int          stall_cnt;

    ma_dmem_if dmem_bus ();

    ma_mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ma_pc_plus_4_in     (pc4),
        .ma_alu_result_in    (alu),
        .ma_write_data_in    (wdata),
        .ma_rd_addr_in       (rd),
        .ma_mem_read_in      (mrd),
        .ma_mem_write_in     (mwr),
        .ma_reg_write_in     (rwe),
        .ma_mem_to_reg_in    (m2r),
        .ma_write_from_pc_in (wfpc),
        .dmem                (dmem_bus),
        .ma_stall            (stall),
        .ma_timeout          (tmo),
        .ma_misalign         (mis),
        .wb_rd_addr_out      (wb_rd),
        .wb_reg_write_out    (wb_we),
        .wb_result_out       (wb_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        pc4 = 32'h0; alu = 32'h0; wdata = 32'h0; rd = 5'd0;
        mrd = 1'b0; mwr = 1'b0; rwe = 1'b0; m2r = 1'b0; wfpc = 1'b0;
        dmem_bus.ready = 1'b0; dmem_bus.rdata = 32'h0;
    endtask

    task automatic count_stall();
        stall_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stall) break;
            stall_cnt = stall_cnt + 1;
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        nop();
        tick();
        tick();
        check("rst_wb_we", {31'd0, wb_we}, 32'd0);
        check("rst_wb_res", wb_res, 32'h0);
        check("rst_timeout", {31'd0, tmo}, 32'd0);
        check("rst_req", {31'd0, dmem_bus.req}, 32'd0);
        rst = 1'b0;

        // 1. ALU op
        alu = 32'h55; rd = 5'd5; rwe = 1'b1;
        #1;
        check("alu_stall", {31'd0, stall}, 32'd0);
        check("alu_req", {31'd0, dmem_bus.req}, 32'd0);
        tick();
        check("alu_res", wb_res, 32'h55);
        check("alu_rd", {27'd0, wb_rd}, 32'd5);
        check("alu_we", {31'd0, wb_we}, 32'd1);

        // 2. LW with three wait cycles
        nop();
        alu = 32'h100; rd = 5'd7; rwe = 1'b1; mrd = 1'b1; m2r = 1'b1;
        #1;
        check("lw_addr", dmem_bus.addr, 32'h100);
        check("lw_we", {31'd0, dmem_bus.we}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("lw_stall", {31'd0, stall}, 32'd1);
            check("lw_req", {31'd0, dmem_bus.req}, 32'd1);
            tick();
            check("lw_bubble_we", {31'd0, wb_we}, 32'd0);
            check("lw_bubble_res", wb_res, 32'h0);
        end
        dmem_bus.ready = 1'b1; dmem_bus.rdata = 32'hDEADBEEF;
        #1;
        check("lw_ready_stall", {31'd0, stall}, 32'd0);
        tick();
        check("lw_res", wb_res, 32'hDEADBEEF);
        check("lw_rd", {27'd0, wb_rd}, 32'd7);
        check("lw_wb_we", {31'd0, wb_we}, 32'd1);

        // 3. SW, zero-wait
        nop();
        alu = 32'h200; wdata = 32'h1234; mwr = 1'b1; dmem_bus.ready = 1'b1;
        #1;
        check("sw_req", {31'd0, dmem_bus.req}, 32'd1);
        check("sw_we", {31'd0, dmem_bus.we}, 32'd1);
        check("sw_addr", dmem_bus.addr, 32'h200);
        check("sw_wdata", dmem_bus.wdata, 32'h1234);
        check("sw_stall", {31'd0, stall}, 32'd0);
        tick();
        check("sw_wb_we", {31'd0, wb_we}, 32'd0);

        // 4. LW that never completes
        nop();
        alu = 32'h300; rd = 5'd9; rwe = 1'b1; mrd = 1'b1; m2r = 1'b1;
        dmem_bus.rdata = 32'hFFFF_FFFF;
        #1;
        count_stall();
        check("to_stall_cnt", stall_cnt, 32'd16);
        check("to_pre_pulse", {31'd0, tmo}, 32'd0);
        tick();
        check("to_pulse", {31'd0, tmo}, 32'd1);
        check("to_res", wb_res, 32'h0);
        check("to_rd", {27'd0, wb_rd}, 32'd9);
        check("to_wb_we", {31'd0, wb_we}, 32'd1);
        nop();
        tick();
        check("to_pulse_end", {31'd0, tmo}, 32'd0);

        // 5. JAL writes PC+4
        pc4 = 32'h40; alu = 32'h999; rd = 5'd1; rwe = 1'b1; wfpc = 1'b1;
        tick();
        check("jal_res", wb_res, 32'h40);

        // Reset in the middle of a WAIT
        nop();
        alu = 32'h400; rd = 5'd3; rwe = 1'b1; mrd = 1'b1; m2r = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rstw_req_acc", {31'd0, dmem_bus.req}, 32'd1);
        check("rstw_wb_we", {31'd0, wb_we}, 32'd0);
        check("rstw_timeout", {31'd0, tmo}, 32'd0);
        mrd = 1'b0;
        #1;
        check("rstw_req_noacc", {31'd0, dmem_bus.req}, 32'd0);
        tick();
        rst = 1'b0;
        mrd = 1'b1;
        #1;
        count_stall();
        check("rstw_cnt_clear", stall_cnt, 32'd16);
        nop();
        tick();

        // Ready without an access is ignored
        dmem_bus.ready = 1'b1;
        #1;
        check("idle_ready_req", {31'd0, dmem_bus.req}, 32'd0);
        check("idle_ready_stall", {31'd0, stall}, 32'd0);
        nop();

        // 6. Misaligned LW
        alu = 32'h102; rd = 5'd4; rwe = 1'b1; mrd = 1'b1; m2r = 1'b1;
        dmem_bus.ready = 1'b1; dmem_bus.rdata = 32'hCAFE_0001;
        #1;
`ifdef MA_MISALIGN_TRAP_EN
        check("mis_req", {31'd0, dmem_bus.req}, 32'd0);
        check("mis_stall", {31'd0, stall}, 32'd0);
        tick();
        check("mis_pulse", {31'd0, mis}, 32'd1);
        check("mis_bubble", {31'd0, wb_we}, 32'd0);
`else
        check("mis_addr", dmem_bus.addr, 32'h100);
        check("mis_req", {31'd0, dmem_bus.req}, 32'd1);
        tick();
        check("mis_flag", {31'd0, mis}, 32'd0);
        check("mis_res", wb_res, 32'hCAFE_0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
